// File: rtl/minesweeper_pkg.sv
// Shared definitions for the minesweeper board logic: placer FSM states and
// default board geometry / mine count.
package minesweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_PLACE = 2'd2,
    ST_DONE  = 2'd3
  } placer_state_e;

  localparam int DEF_ROW_BITS = 4;
  localparam int DEF_COL_BITS = 4;
  localparam int DEF_MINES    = 40;

endpackage

// File: rtl/mine_safe_check.sv
// Combinational test of whether a candidate cell lies in the region around
// the first click that must stay mine-free.
// MINE_PLACER_SAFE_ZONE_EN: when defined the region is the 3x3 block around
// the click, clipped at the board edges; otherwise only the clicked cell.
module mine_safe_check #(
  parameter int ROW_BITS = 4,
  parameter int COL_BITS = 4
) (
  input  logic [ROW_BITS-1:0] cand_row,
  input  logic [COL_BITS-1:0] cand_col,
  input  logic [ROW_BITS-1:0] safe_row,
  input  logic [COL_BITS-1:0] safe_col,
  output logic                in_safe
);

`ifdef MINE_PLACER_SAFE_ZONE_EN
  logic row_near;
  logic col_near;

  // Neighbour tests are guarded at each edge so a border cell never reaches across the board
  always_comb begin
    row_near = (cand_row == safe_row)
            || ((safe_row != {ROW_BITS{1'b1}}) && (cand_row == safe_row + ROW_BITS'(1)))
            || ((safe_row != '0) && (cand_row == safe_row - ROW_BITS'(1)));
    col_near = (cand_col == safe_col)
            || ((safe_col != {COL_BITS{1'b1}}) && (cand_col == safe_col + COL_BITS'(1)))
            || ((safe_col != '0) && (cand_col == safe_col - COL_BITS'(1)));
    in_safe  = row_near && col_near;
  end
`else
  // Only the clicked cell itself is protected
  always_comb begin
    in_safe = (cand_row == safe_row) && (cand_col == safe_col);
  end
`endif

endmodule

// File: rtl/mine_placer.sv
// Mine placer: clears the board, then places MINES mines at random cells
// taken from an LFSR stream, skipping duplicates and the first-click region.
// Optional feature macro MINE_PLACER_SAFE_ZONE_EN widens the protected
// region to a 3x3 block (see mine_safe_check).
module mine_placer
  import minesweeper_pkg::*;
#(
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int COL_BITS = DEF_COL_BITS,
  parameter int MINES    = DEF_MINES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ROW_BITS-1:0]          safe_row,
  input  logic [COL_BITS-1:0]          safe_col,
  input  logic                         rnd_valid,
  input  logic [ROW_BITS+COL_BITS-1:0] rnd_data,
  output logic                         rnd_ready,
  output logic                         wr_en,
  output logic [ROW_BITS+COL_BITS-1:0] wr_addr,
  output logic                         wr_mine,
  output logic                         busy,
  output logic                         done,
  output logic [ROW_BITS+COL_BITS-1:0] placed
);

  localparam int IDX_W = ROW_BITS + COL_BITS;
  localparam int CELLS = 1 << IDX_W;

  // Nine cells around the first click must always remain free
  if (MINES > CELLS - 9) begin : g_mines_check
    $error("mine_placer: MINES must not exceed CELLS-9");
  end

  placer_state_e         state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [CELLS-1:0]      bitmap_q, bitmap_d;
  logic [IDX_W-1:0]      placed_q, placed_d;
  logic [ROW_BITS-1:0]   safe_row_q, safe_row_d;
  logic [COL_BITS-1:0]   safe_col_q, safe_col_d;
  logic                  wr_en_q, wr_en_d;
  logic [IDX_W-1:0]      wr_addr_q, wr_addr_d;
  logic                  wr_mine_q, wr_mine_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rnd_ready_q, rnd_ready_d;
  logic                  in_safe;

  mine_safe_check #(
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS)
  ) u_safe_check (
    .cand_row (rnd_data[IDX_W-1:COL_BITS]),
    .cand_col (rnd_data[COL_BITS-1:0]),
    .safe_row (safe_row_q),
    .safe_col (safe_col_q),
    .in_safe  (in_safe)
  );

  // Next-state and next-output logic; every output is registered so a mine
  // write appears the cycle after its word is accepted
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitmap_d    = bitmap_q;
    placed_d    = placed_q;
    safe_row_d  = safe_row_q;
    safe_col_d  = safe_col_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_mine_d   = wr_mine_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rnd_ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_CLEAR;
          cnt_d      = '0;
          bitmap_d   = '0;
          placed_d   = '0;
          safe_row_d = safe_row;
          safe_col_d = safe_col;
          wr_en_d    = 1'b1;
          wr_addr_d  = '0;
          wr_mine_d  = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == IDX_W'(CELLS - 1)) begin
          if (MINES == 0) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d     = ST_PLACE;
            rnd_ready_d = 1'b1;
          end
        end else begin
          cnt_d     = cnt_q + IDX_W'(1);
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q + IDX_W'(1);
          wr_mine_d = 1'b0;
        end
      end
      ST_PLACE: begin
        rnd_ready_d = 1'b1;
        if (rnd_valid && rnd_ready_q && !bitmap_q[rnd_data] && !in_safe) begin
          bitmap_d[rnd_data] = 1'b1;
          placed_d           = placed_q + IDX_W'(1);
          wr_en_d            = 1'b1;
          wr_addr_d          = rnd_data;
          wr_mine_d          = 1'b1;
          if (placed_q + IDX_W'(1) == IDX_W'(MINES)) begin
            state_d     = ST_DONE;
            rnd_ready_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear of the whole game
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bitmap_q    <= '0;
      placed_q    <= '0;
      safe_row_q  <= '0;
      safe_col_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_mine_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rnd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitmap_q    <= bitmap_d;
      placed_q    <= placed_d;
      safe_row_q  <= safe_row_d;
      safe_col_q  <= safe_col_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_mine_q   <= wr_mine_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rnd_ready_q <= rnd_ready_d;
    end
  end

  assign rnd_ready = rnd_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_mine   = wr_mine_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign placed    = placed_q;

endmodule

// File: tb/tb_mine_placer.sv
// Scoreboard bench for mine_placer with the default 16x16 board, 40 mines.
// Expected board writes are queued as stimulus is issued and a monitor
// compares every write the DUT makes against the queue.
module tb_mine_placer;

  typedef struct packed {
    logic [7:0] addr;
    logic       mine;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] safe_row = '0;
  logic [3:0] safe_col = '0;
  logic       rnd_valid = 1'b0;
  logic [7:0] rnd_data = '0;
  logic       rnd_ready;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic       wr_mine;
  logic       busy;
  logic       done;
  logic [7:0] placed;

  int  checks = 0;
  int  errors = 0;
  int  doneCount = 0;
  int  doneBefore;
  wr_t expQ[$];

  mine_placer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .safe_row  (safe_row),
    .safe_col  (safe_col),
    .rnd_valid (rnd_valid),
    .rnd_data  (rnd_data),
    .rnd_ready (rnd_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_mine   (wr_mine),
    .busy      (busy),
    .done      (done),
    .placed    (placed)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Monitor: every board write must match the head of the expectation queue
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wr_t exp;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write actual addr=%02h mine=%0b required none", wr_addr, wr_mine);
      end else begin
        exp = expQ.pop_front();
        if (wr_addr !== exp.addr || wr_mine !== exp.mine) begin
          errors++;
          $display("[TB] FAIL board_write actual addr=%02h mine=%0b required addr=%02h mine=%0b",
                   wr_addr, wr_mine, exp.addr, exp.mine);
        end
      end
    end
    if (rst_n && done) doneCount++;
  end

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual %0d required %0d", name, actual, required);
    end
  endtask

  task automatic expectMine(input logic [7:0] a);
    wr_t e;
    e.addr = a;
    e.mine = 1'b1;
    expQ.push_back(e);
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    rnd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_wr_mine", wr_mine, 0);
    checkOutput("rst_rnd_ready", rnd_ready, 0);
    checkOutput("rst_placed", placed, 0);
    rst_n = 1'b1;
  endtask

  // Start a game, queue the full clear sequence and wait for PLACE to open
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] c, input bit restartMid);
    wr_t e;
    int  cyc;
    @(negedge clk);
    safe_row = r;
    safe_col = c;
    start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      e.addr = 8'(i);
      e.mine = 1'b0;
      expQ.push_back(e);
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = (restartMid && cyc == 100);
      if (cyc == 10) checkOutput("clear_busy", busy, 1);
    end while (!rnd_ready && cyc < 400);
    start = 1'b0;
    rnd_valid = 1'b0;
    checkOutput("clear_len", cyc, 257);
    checkOutput("clear_placed", placed, 0);
  endtask

  // Present one word; it is consumed on the next rising edge
  task automatic feedWord(input logic [7:0] w);
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    while (!rnd_ready && waitCnt < 600) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!rnd_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL feed_timeout actual rnd_ready=0 required 1 word=%02h", w);
    end
    rnd_valid = 1'b1;
    rnd_data = w;
  endtask

  task automatic finishFeed();
    @(negedge clk);
    rnd_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int expPlaced;

    $display("[TB] reset and clear");
    rnd_valid = 1'b1;
    rnd_data = 8'h12;
    applyReset();
    rnd_valid = 1'b1;
    applyStimulus(4'h0, 4'h0, 1'b0);
    checkOutput("clear_queue_drained", expQ.size(), 0);

    $display("[TB] duplicate rejection");
    applyReset();
    applyStimulus(4'h0, 4'h0, 1'b0);
    expectMine(8'h55);
    expectMine(8'h56);
    feedWord(8'h55);
    feedWord(8'h55);
    feedWord(8'h56);
    finishFeed();
    checkOutput("dup_placed", placed, 2);
    checkOutput("dup_queue", expQ.size(), 0);

    $display("[TB] safe zone around (7,7)");
    applyReset();
    applyStimulus(4'h7, 4'h7, 1'b0);
`ifdef MINE_PLACER_SAFE_ZONE_EN
    expectMine(8'h69);
    expPlaced = 1;
`else
    expectMine(8'h66);
    expectMine(8'h68);
    expectMine(8'h88);
    expectMine(8'h69);
    expPlaced = 4;
`endif
    feedWord(8'h66);
    feedWord(8'h68);
    feedWord(8'h88);
    feedWord(8'h77);
    feedWord(8'h69);
    finishFeed();
    checkOutput("zone_placed", placed, expPlaced);
    checkOutput("zone_queue", expQ.size(), 0);

    $display("[TB] edge at (0,0)");
    applyReset();
    applyStimulus(4'h0, 4'h0, 1'b0);
    expectMine(8'hF0);
    expectMine(8'h0F);
`ifdef MINE_PLACER_SAFE_ZONE_EN
    expPlaced = 2;
`else
    expectMine(8'h11);
    expPlaced = 3;
`endif
    feedWord(8'hF0);
    feedWord(8'h0F);
    feedWord(8'h11);
    finishFeed();
    checkOutput("edge_placed", placed, expPlaced);
    checkOutput("edge_queue", expQ.size(), 0);

    $display("[TB] completion with start while busy");
    applyReset();
    applyStimulus(4'h0, 4'h0, 1'b1);
    doneBefore = doneCount;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] w;
      w = 8'h20 + 8'(i);
      start = (i == 20);
      expectMine(w);
      feedWord(w);
    end
    start = 1'b0;
    @(negedge clk);
    rnd_data = 8'h99;
    checkOutput("final_rnd_ready", rnd_ready, 0);
    checkOutput("final_done", done, 1);
    checkOutput("final_busy", busy, 0);
    checkOutput("final_placed", placed, 40);
    @(negedge clk);
    checkOutput("done_one_cycle", done, 0);
    repeat (4) @(negedge clk);
    rnd_valid = 1'b0;
    checkOutput("done_pulses", doneCount - doneBefore, 1);
    checkOutput("placed_hold", placed, 40);
    checkOutput("complete_queue", expQ.size(), 0);

    $display("[TB] reset mid-place");
    applyReset();
    applyStimulus(4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      expectMine(8'h30 + 8'(i));
      feedWord(8'h30 + 8'(i));
    end
    finishFeed();
    checkOutput("mid_placed_before", placed, 10);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_placed", placed, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_ready", rnd_ready, 0);
    rst_n = 1'b1;
    doneBefore = doneCount;
    applyStimulus(4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      expectMine(8'h30 + 8'(i));
      feedWord(8'h30 + 8'(i));
    end
    @(negedge clk);
    rnd_valid = 1'b0;
    checkOutput("regame_done", done, 1);
    repeat (3) @(negedge clk);
    checkOutput("regame_pulses", doneCount - doneBefore, 1);
    checkOutput("regame_placed", placed, 40);
    checkOutput("regame_queue", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mine_placer.md
MINE_PLACER -- requirements
Module: mine_placer

Interface
REQ-001 SHALL have parameter ROW_BITS, default 4: row index width; board has 2^ROW_BITS rows.
REQ-002 SHALL have parameter COL_BITS, default 4: column index width; board has 2^COL_BITS columns.
REQ-003 SHALL have parameter MINES, default 40: mines placed per game; IDX_W = ROW_BITS+COL_BITS, CELLS = 2^IDX_W.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1: begin a new placement.
REQ-007 SHALL have port safe_row, input, ROW_BITS: row of first click, sampled on accepted start.
REQ-008 SHALL have port safe_col, input, COL_BITS: column of first click, sampled on accepted start.
REQ-009 SHALL have port rnd_valid, input, 1: random word available from the LFSR source.
REQ-010 SHALL have port rnd_data, input, IDX_W: random candidate cell index, {row, col}.
REQ-011 SHALL have port rnd_ready, output, 1: placer consumes rnd_data this cycle.
REQ-012 SHALL have port wr_en, output, 1: board write strobe.
REQ-013 SHALL have port wr_addr, output, IDX_W: board cell written.
REQ-014 SHALL have port wr_mine, output, 1: value written; 0 = clear, 1 = mine.
REQ-015 SHALL have port busy, output, 1: high in CLEAR and PLACE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse on completion.
REQ-017 SHALL have port placed, output, IDX_W: mines placed so far this game.

Function
REQ-018 SHALL implement states IDLE, CLEAR, PLACE, DONE.
REQ-019 SHALL move IDLE->CLEAR on start; start SHALL be ignored in all other states.
REQ-020 SHALL, in CLEAR, write wr_mine=0 to addresses 0..CELLS-1 in order, one per cycle; it SHALL also zero the internal CELLS-bit mine bitmap; it SHALL zero placed; CLEAR SHALL last exactly CELLS cycles, then enter PLACE.
REQ-021 SHALL assert rnd_ready only in PLACE; a word is consumed only when rnd_valid && rnd_ready.
REQ-022 SHALL accept a consumed word only if its bitmap bit is 0 and the word lies outside the safe region; otherwise it SHALL discard the word with no write.
REQ-023 SHALL, on acceptance, set the bitmap bit and increment placed in the same edge; it SHALL assert wr_en=1, wr_mine=1, wr_addr=word exactly one cycle later.
REQ-024 SHALL deassert rnd_ready in the cycle placed reaches MINES, then enter DONE; no further words are consumed.
REQ-025 SHALL pulse done for the single DONE cycle, then return to IDLE; placed SHALL hold its value until the next CLEAR.
REQ-026 SHALL compute safe-region membership without wrap-around: a cell at a board edge has no neighbours across the opposite edge.
REQ-027 SHALL handle back-to-back valid words at one per cycle; duplicate words in consecutive cycles SHALL be detected.
REQ-028 SHALL require MINES <= CELLS-9, checked at elaboration.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-CLEAR or mid-PLACE, go to IDLE and zero busy, done, wr_en, wr_addr, wr_mine, rnd_ready, placed, the bitmap and the latched safe row/col.

Configuration
REQ-030 SHALL, with MINE_PLACER_SAFE_ZONE_EN defined, define the safe region as the 3x3 block centred on (safe_row, safe_col), clipped at edges.
REQ-031 SHALL, without MINE_PLACER_SAFE_ZONE_EN, define the safe region as the single cell (safe_row, safe_col).

Structure
REQ-032 SHALL place the state enum and the default ROW_BITS/COL_BITS/MINES constants in minesweeper_pkg.
REQ-033 SHALL implement safe-region membership in a combinational sub-module, mine_safe_check.

Verification
REQ-034 SHALL verify reset: rst_n low for 3 cycles, then start, rnd_valid=1 -> CLEAR runs 256 cycles of wr_mine=0 at addr 0..255, then rnd_ready rises.
REQ-035 SHALL verify duplicate rejection: safe (0,0); feed 0x55, 0x55, 0x56 -> exactly two writes, addr 0x55 then 0x56; placed=2.
REQ-036 SHALL verify the safe zone with MINE_PLACER_SAFE_ZONE_EN: safe (7,7); feed 0x66,0x68,0x88,0x77,0x69 -> only 0x69 written; without the macro, all except 0x77 written.
REQ-037 SHALL verify the edge: with the macro, safe (0,0); feed 0xF0,0x0F,0x11 -> 0xF0 and 0x0F written, 0x11 discarded.
REQ-038 SHALL verify completion: MINES=40, distinct non-safe words -> exactly 40 mine writes, done pulses once, rnd_ready low after the 40th accept, and start is ignored while busy.
REQ-039 SHALL verify reset mid-PLACE: rst_n low after 10 mines -> placed=0, busy=0; next start re-clears the board and places 40 fresh mines.
